// File: rtl/adc_serial_reader_pkg.sv
// Shared types and sizing for the ADC serial reader: FSM states, counter width
// and the frame-length helper used to detect an over-short sample period.
package adc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CONVERT,
        SHIFT,
        DONE,
        WAIT
    } state_t;

    localparam int CNT_W = 16;

    localparam int DEF_DATA_BITS     = 16;
    localparam int DEF_CLK_DIV       = 2;
    localparam int DEF_CONV_CYCLES   = 10;
    localparam int DEF_SAMPLE_PERIOD = 100;

    // Cycles from the first CONVERT cycle through DONE inclusive.
    function automatic int frame_cycles(input int data_bits, input int clk_div,
                                        input int conv_cycles);
        return conv_cycles + 2 * clk_div * data_bits + 1;
    endfunction

    localparam int FRAME_CYCLES = frame_cycles(DEF_DATA_BITS, DEF_CLK_DIV, DEF_CONV_CYCLES);

endpackage

// File: rtl/adc_serial_reader_if.sv
// ADC pin bundle plus the parallel sample output toward adc_wrapper.
interface adc_serial_reader_if #(
    parameter int DATA_BITS = 16
);
    logic                 adc_convst;
    logic                 adc_cs_n;
    logic                 adc_sck;
    logic                 adc_sdo;
    logic [DATA_BITS-1:0] adc_data;
    logic                 adc_ready;
    logic                 frame_overrun;

    modport master (
        output adc_convst, adc_cs_n, adc_sck, adc_data, adc_ready, frame_overrun,
        input  adc_sdo
    );

    modport slave (
        input  adc_convst, adc_cs_n, adc_sck, adc_data, adc_ready, frame_overrun,
        output adc_sdo
    );
endinterface

// File: rtl/adc_serial_reader_sck_gen.sv
// SCK generator for one SHIFT phase: low half first, DATA_BITS periods of
// 2*CLK_DIV cycles, with strobes for the sampling edge and the final period.
module adc_sck_gen
    import adc_pkg::*;
#(
    parameter int DATA_BITS = 16,
    parameter int CLK_DIV   = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic sck,
    output logic rise,
    output logic done
);
    logic [CNT_W-1:0] half_cnt;
    logic [CNT_W-1:0] bit_cnt;
    logic             hi;
    logic             half_end;

    assign half_end = (half_cnt == CNT_W'(CLK_DIV - 1));

    always_ff @(posedge clk) begin
        if (reset || !run) begin
            half_cnt <= '0;
            bit_cnt  <= '0;
            hi       <= 1'b0;
        end else if (half_end) begin
            half_cnt <= '0;
            hi       <= !hi;
            if (hi)
                bit_cnt <= bit_cnt + 1'b1;
        end else begin
            half_cnt <= half_cnt + 1'b1;
        end
    end

    // Idles high outside SHIFT so the pin rests high without extra state.
    assign sck  = run ? hi : 1'b1;
    assign rise = run && !hi && half_end;
    assign done = run && hi && half_end && (bit_cnt == CNT_W'(DATA_BITS - 1));

endmodule

// File: rtl/adc_serial_reader.sv
// Drives a SPI-style sampling ADC at a fixed sample period and presents each
// conversion as a parallel word with a one-cycle adc_ready strobe.
module adc_serial_reader
    import adc_pkg::*;
#(
    parameter int DATA_BITS     = 16,
    parameter int CLK_DIV       = 2,
    parameter int CONV_CYCLES   = 10,
    parameter int SAMPLE_PERIOD = 100,
    parameter bit INVERT_MSB    = 1'b0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    adc_serial_reader_if.master bus
);
    localparam int FRAME = frame_cycles(DATA_BITS, CLK_DIV, CONV_CYCLES);
    // A period equal to the frame length needs no WAIT cycle but is not an overrun.
    localparam bit SKIP_WAIT = (SAMPLE_PERIOD <= FRAME);
    localparam bit OVERRUN   = (SAMPLE_PERIOD < FRAME);
    localparam logic [DATA_BITS-1:0] MSB_MASK = {INVERT_MSB, {(DATA_BITS-1){1'b0}}};

    state_t               state, state_d;
    logic [CNT_W-1:0]     conv_cnt;
    logic [CNT_W-1:0]     period_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic [DATA_BITS-1:0] data_q;
    logic                 ovr_q;
    logic                 shift_run;
    logic                 sck_rise;
    logic                 sck_done;
    logic                 start;

    assign shift_run = (state == SHIFT);

    adc_sck_gen #(
        .DATA_BITS (DATA_BITS),
        .CLK_DIV   (CLK_DIV)
    ) u_sck (
        .clk   (clk),
        .reset (reset),
        .run   (shift_run),
        .sck   (bus.adc_sck),
        .rise  (sck_rise),
        .done  (sck_done)
    );

    always_comb begin
        state_d = state;
        unique case (state)
            IDLE:    if (enable) state_d = CONVERT;
            CONVERT: if (conv_cnt == CNT_W'(CONV_CYCLES - 1)) state_d = SHIFT;
            SHIFT:   if (sck_done) state_d = DONE;
            DONE: begin
                if (SKIP_WAIT) state_d = enable ? CONVERT : IDLE;
                else           state_d = WAIT;
            end
            WAIT: begin
                if (period_cnt >= CNT_W'(SAMPLE_PERIOD - 1))
                    state_d = enable ? CONVERT : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Every fresh CONVERT entry marks T0 of a frame.
    assign start = (state_d == CONVERT) && (state != CONVERT);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            conv_cnt   <= '0;
            period_cnt <= '0;
            shreg      <= '0;
            data_q     <= '0;
            ovr_q      <= 1'b0;
        end else begin
            state    <= state_d;
            conv_cnt <= (state == CONVERT && state_d == CONVERT) ? conv_cnt + 1'b1 : '0;

            if (start)
                period_cnt <= '0;
            else if (period_cnt != '1)
                period_cnt <= period_cnt + 1'b1;

            if (sck_rise)
                shreg <= {shreg[DATA_BITS-2:0], bus.adc_sdo};

            if (shift_run && sck_done)
                data_q <= shreg ^ MSB_MASK;

            if (state == DONE && OVERRUN)
                ovr_q <= 1'b1;
        end
    end

    assign bus.adc_convst    = (state == CONVERT);
    assign bus.adc_cs_n      = (state != SHIFT);
    assign bus.adc_data      = data_q;
    assign bus.adc_ready     = (state == DONE);
    assign bus.frame_overrun = ovr_q;

endmodule
